// File: rtl/regfile_dump_pkg.sv
// Shared constants, types and FSM encoding for the register-file dump reader.
// Also holds the header-byte helper used by the dump FSM.
package regfile_dump_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int NBYTES = XLEN / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_LATCH,
    S_SEND_IDX,
    S_SEND_DATA,
    S_FINISH
  } dump_state_t;

  // The header byte is the register index, zero-extended.
  function automatic logic [7:0] header_byte(reg_addr_t idx);
    return 8'(idx);
  endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Byte stream from the dump reader to the debug UART transmitter.
interface regfile_dump_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/regfile_dump_byte_serializer.sv
// Holds one captured register word and hands it out LSB-first, one byte per
// valid/ready handshake, flagging the final byte with o_last.
module regfile_dump_byte_serializer
  import regfile_dump_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  word_t      i_word,
  input  logic       i_en,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  output logic       o_fire
);

  word_t         r_word;
  logic [CW-1:0] r_cnt;

  assign o_valid = i_en;
  assign o_data  = r_word[7:0];
  assign o_last  = (r_cnt == CW'(NBYTES - 1));
  assign o_fire  = o_valid && i_ready;

  // The counter wraps back to zero on the final byte so it rests at 0 between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_cnt  <= '0;
    end else if (o_fire) begin
      r_word <= r_word >> 8;
      r_cnt  <= o_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_dump.sv
// Halts the core, walks every register through the debug read port and streams
// each one as an index byte followed by its data bytes, LSB first.
module regfile_dump
  import regfile_dump_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic              o_cpu_halt,
  output reg_addr_t         o_ra,
  input  word_t             i_rd,
  regfile_dump_if.master    tx,
  output logic              o_busy,
  output logic              o_done
);

  dump_state_t r_state;
  dump_state_t w_next;
  reg_addr_t   r_idx;
  reg_addr_t   w_idx_next;

  logic       w_ser_valid;
  logic [7:0] w_ser_data;
  logic       w_ser_last;
  logic       w_ser_fire;

  // r_idx is zero outside a dump, so the read port idles at address 0.
  assign o_ra = r_idx;

  regfile_dump_byte_serializer u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (r_state == S_LATCH),
    .i_word  (i_rd),
    .i_en    (r_state == S_SEND_DATA),
    .i_ready (tx.tx_ready),
    .o_valid (w_ser_valid),
    .o_data  (w_ser_data),
    .o_last  (w_ser_last),
    .o_fire  (w_ser_fire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_idx_next  = r_idx;
    o_cpu_halt  = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    tx.tx_valid = 1'b0;
    tx.tx_data  = '0;
    case (r_state)
      S_IDLE: begin
        w_idx_next = '0;
        if (i_start) w_next = S_HALT;
      end
      S_HALT: begin
        o_cpu_halt = 1'b1;
        o_busy     = 1'b1;
        w_next     = S_LATCH;
      end
      S_LATCH: begin
        o_cpu_halt = 1'b1;
        o_busy     = 1'b1;
        w_next     = S_SEND_IDX;
      end
      S_SEND_IDX: begin
        o_cpu_halt  = 1'b1;
        o_busy      = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_data  = header_byte(r_idx);
        if (tx.tx_ready) w_next = S_SEND_DATA;
      end
      S_SEND_DATA: begin
        o_cpu_halt  = 1'b1;
        o_busy      = 1'b1;
        tx.tx_valid = w_ser_valid;
        tx.tx_data  = w_ser_data;
        if (w_ser_fire && w_ser_last) begin
          if (r_idx == reg_addr_t'(NREGS - 1)) begin
            w_next = S_FINISH;
          end else begin
            w_idx_next = r_idx + 1'b1;
            w_next     = S_LATCH;
          end
        end
      end
      S_FINISH: begin
        o_cpu_halt = 1'b1;
        o_busy     = 1'b1;
        o_done     = 1'b1;
        w_idx_next = '0;
        w_next     = S_IDLE;
      end
      default: begin
        w_idx_next = '0;
        w_next     = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a behavioural register file and a
// frame model built from register contents, checked byte by byte.
module tb_regfile_dump;

  localparam int NR    = 32;
  localparam int NB    = 4;
  localparam int FRAME = NR * (1 + NB);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cpuHalt;
  logic        busy;
  logic        done;
  logic [4:0]  ra;
  logic [31:0] rd;
  logic [31:0] rf [NR];

  regfile_dump_if txIf ();

  int nVectors = 0;
  int nMiscompares = 0;
  int cyc = 0;
  int doneCount = 0;
  int doneCycle = 0;
  int readyMode = 0;

  logic [7:0] got[$];
  logic [7:0] expStream[$];
  logic       stalled = 1'b0;
  logic [7:0] stallData = '0;

  typedef struct {
    int          regIdx;
    logic [39:0] bytes;
  } vec_t;

  regfile_dump dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .o_cpu_halt (cpuHalt),
    .o_ra       (ra),
    .i_rd       (rd),
    .tx         (txIf),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  // x0 reads as zero no matter what is stored behind it.
  assign rd = (ra == 5'd0) ? 32'h0 : rf[ra];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       txIf.tx_ready = 1'b1;
      1:       txIf.tx_ready = ($urandom_range(0, 99) < 30);
      default: txIf.tx_ready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Stream monitor: records accepted bytes, checks stall stability, counts done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        checkOutput("stall_valid", 32'(txIf.tx_valid), 32'd1);
        checkOutput("stall_data", 32'(txIf.tx_data), 32'(stallData));
      end
      if (txIf.tx_valid && txIf.tx_ready) got.push_back(txIf.tx_data);
      stalled   = txIf.tx_valid && !txIf.tx_ready;
      stallData = txIf.tx_data;
      if (done) begin
        doneCount++;
        doneCycle = cyc;
      end
    end
  end

  task automatic buildExpected();
    logic [31:0] w;
    expStream.delete();
    for (int i = 0; i < NR; i++) begin
      expStream.push_back(8'(i));
      w = (i == 0) ? 32'h0 : rf[i];
      for (int b = 0; b < NB; b++) expStream.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic applyStimulus(input int pulseAt, input int writeAt, input bit checkTiming);
    int  startCycle;
    bit  pulsed;
    bit  written;
    int  n;
    buildExpected();
    got.delete();
    doneCount = 0;
    pulsed = 0;
    written = 0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    startCycle = cyc;
    for (int k = 0; k < 4000 && doneCount == 0; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (pulseAt >= 0 && !pulsed && got.size() >= pulseAt) begin
        pulsed = 1;
        start  = 1'b1;
      end
      if (writeAt >= 0 && !written && got.size() >= writeAt) begin
        written = 1;
        if (!cpuHalt) rf[5] = 32'h12345678;
      end
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(doneCount > 0), 32'd1);
    if (checkTiming && doneCount > 0)
      checkOutput("done_cycle", 32'(doneCycle - startCycle + 1), 32'd194);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("done_once", 32'(doneCount), 32'd1);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("halt_after", 32'(cpuHalt), 32'd0);
    checkOutput("valid_after", 32'(txIf.tx_valid), 32'd0);
    checkOutput("stream_len", 32'(got.size()), 32'(expStream.size()));
    n = (got.size() < expStream.size()) ? got.size() : expStream.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("byte%0d", i), 32'(got[i]), 32'(expStream[i]));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_halt"}, 32'(cpuHalt), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_valid"}, 32'(txIf.tx_valid), 32'd0);
    checkOutput({tag, "_data"}, 32'(txIf.tx_data), 32'd0);
    checkOutput({tag, "_ra"}, 32'(ra), 32'd0);
  endtask

  initial begin
    vec_t table_[5];
    int   pos;

    for (int i = 0; i < NR; i++) rf[i] = 32'h01010101 * i;
    rf[0] = 32'hDEADBEEF;

    readyMode = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkResetOutputs("idle");

    $display("[TB] full dump, ready tied high");
    applyStimulus(-1, -1, 1'b1);

    table_[0] = '{regIdx: 0,  bytes: 40'h0000000000};
    table_[1] = '{regIdx: 3,  bytes: 40'h0303030303};
    table_[2] = '{regIdx: 10, bytes: 40'h0A0A0A0A0A};
    table_[3] = '{regIdx: 16, bytes: 40'h1010101010};
    table_[4] = '{regIdx: 31, bytes: 40'h1F1F1F1F1F};
    for (int t = 0; t < 5; t++) begin
      for (int j = 0; j < 1 + NB; j++) begin
        pos = table_[t].regIdx * (1 + NB) + j;
        checkOutput($sformatf("tbl_r%0d_b%0d", table_[t].regIdx, j),
                    32'(got[pos]), 32'(table_[t].bytes[39 - 8*j -: 8]));
      end
    end

    $display("[TB] start pulsed again during byte 40");
    applyStimulus(40, -1, 1'b1);

    $display("[TB] random contents, ready at 30%%");
    for (int i = 0; i < NR; i++) rf[i] = $urandom;
    readyMode = 1;
    applyStimulus(-1, -1, 1'b0);
    readyMode = 0;

    $display("[TB] core write to x5 while halted");
    rf[5] = 32'hCAFE0005;
    applyStimulus(-1, 2, 1'b1);

    $display("[TB] reset during register 10 data bytes");
    got.delete();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2000 && got.size() < 52; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("reached_r10", 32'(got.size() >= 52), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(-1, -1, 1'b1);
    checkOutput("restart_hdr", 32'(got[0]), 32'd0);
    checkOutput("restart_len", 32'(got.size()), 32'(FRAME));

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug reader for the CPU's 32x32 register file.
- On a start pulse, it halts the core, walks every architectural register through a spare combinational read port, and streams the contents out as bytes over a valid/ready interface.
- The byte stream feeds the debug UART transmitter.
- The block sits beside the register file and never writes it.

Parameters:
- NREGS, 32, number of registers dumped, indices 0..NREGS-1.
- XLEN, 32, register width in bits; must be a multiple of 8.
- AW, 5, register address width; must satisfy 2**AW >= NREGS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  dump request; sampled only in IDLE.
- cpu_halt  output  1  asks the core to freeze register-file writes while the dump runs.
- ra  output  AW  read address to the register file's debug read port.
- rd  input  XLEN  combinational read data for address ra.
- tx_data  output  8  stream byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  consumer accepts the byte.
- busy  output  1  dump in progress.
- done  output  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low: rst_n low forces state IDLE immediately.
- Values in IDLE and while rst_n is low:
  - cpu_halt=0, busy=0, done=0, tx_valid=0.
  - tx_data=0, ra=0, idx=0, byte counter=0.
- Frame format, per register i, 1+XLEN/8 bytes:
  - Byte 0 is i, zero-extended to 8 bits.
  - The data bytes follow, least-significant byte first.
- Total frame: NREGS*(1+XLEN/8) bytes, which is 160 at default parameters.
- FSM states: IDLE, HALT, LATCH, SEND_IDX, SEND_DATA, FINISH.
- IDLE:
  - start=1 moves to HALT.
  - start in any other state is ignored; no queuing.
- HALT:
  - cpu_halt=1 and busy=1 from this state until FINISH inclusive.
  - Spend exactly one cycle here so any in-flight write completes, then go to LATCH.
- LATCH:
  - ra=idx; rd is captured into word_q on the edge leaving LATCH.
  - ra holds idx in all states after LATCH.
  - The captured value, not a live read, is what gets sent.
  - x0 is sent as whatever the port returns; the register file returns 0.
  - Next state: SEND_IDX.
- SEND_IDX:
  - tx_valid=1, tx_data=idx[7:0].
  - On tx_valid&&tx_ready, go to SEND_DATA with byte counter=0.
- SEND_DATA:
  - tx_valid=1, tx_data=word_q[7:0].
  - On each handshake, shift word_q right by 8 and increment the byte counter.
  - After byte XLEN/8-1 is accepted: if idx==NREGS-1, go to FINISH; otherwise idx+=1 and go to LATCH.
- Stream rules:
  - Once tx_valid is high, tx_valid and tx_data stay stable until the handshake.
  - tx_valid never drops without a handshake, except under reset.
  - tx_ready held low stalls indefinitely with no timeout.
- Stream throughput:
  - With tx_ready tied high: 1 cycle per byte, plus 1 LATCH cycle per register, plus HALT and FINISH.
  - Total 194 cycles from start to done at default parameters.
- FINISH:
  - done=1 for exactly one cycle; cpu_halt and busy fall in the same cycle.
  - Next state: IDLE; idx returns to 0.
- Reset mid-dump:
  - Aborts immediately; the partial frame is abandoned and cpu_halt drops asynchronously.
  - A new start afterwards restarts from register 0.
- Index arithmetic: idx is AW bits and never wraps past NREGS-1; the last-register test uses equality.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN, NREGS, AW, the register address type and the data word type, shared with register_file.
  - The dump FSM state enum, dump_state_t.
- One natural sub-module: byte_serializer.
  - Loads an XLEN word and emits LSB-first bytes over valid/ready.
  - Asserts last on the final byte.
  - The top block owns the FSM, idx, halt and the header byte.

Test Plan:
- Register file preloaded with rf[i]=32'h01010101*i, tx_ready=1, start pulse -> 160 bytes.
  - Register 3 emits bytes 03,03,03,03,03.
  - Register 31 emits bytes 1F,1F,1F,1F,1F.
  - done pulses once, on cycle 194 after start.
- x0 check, with rf[0] holding garbage 32'hDEADBEEF -> bytes 00,00,00,00,00 are sent for register 0.
- tx_ready driven pseudo-random at 30% -> same 160-byte sequence.
  - tx_data and tx_valid remain stable across every stalled cycle.
  - The scoreboard sees no lost or duplicated byte.
- Core attempts a write to x5 (we=1, wd=32'h12345678) while cpu_halt=1 -> this is the core-side freeze test.
  - The write is suppressed by the core.
  - The dump shows the pre-start value of x5.
- start pulsed again during byte 40 -> ignored; the stream completes normally with a single done.
- rst_n low during register 10's data bytes:
  - Outputs go to reset values within the same cycle.
  - A start after release restarts from header byte 00.
